// File: rtl/branch_pc_unit.sv
// Program-counter / next-address stage behind the 8-bit ALU: sequential fetch, jumps,
// conditional branches resolved by the ALU zero flag with a bounded wait. Optional LIFO under CALL_STACK_EN.
module branch_pc_unit_checker #(
  parameter int PC_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  input logic [PC_W-1:0] pc,
  input logic            pc_valid,
  input logic            busy,
  input logic            br_timeout,
  input logic            stack_err
);
  logic unused_pc_s;
  assign unused_pc_s = ^pc;

  a_valid_busy_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(pc_valid && busy));
  a_timeout_only_busy:    assert property (@(posedge clk) disable iff (!rst_n) br_timeout |-> busy);
  a_stack_err_sticky:     assert property (@(posedge clk) disable iff (!rst_n) $past(stack_err) |-> stack_err);
endmodule

module branch_pc_unit #(
  parameter int PC_W        = 8,
  parameter int RESET_PC    = 0,
  parameter int WAIT_MAX    = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic            is_branch,
  input  logic            is_jump,
  input  logic            is_call,
  input  logic            is_ret,
  input  logic [7:0]      br_offset,
  input  logic [PC_W-1:0] jump_target,
  input  logic            alu_zero,
  input  logic            alu_done,
  input  logic            stall,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic            busy,
  output logic            br_timeout,
  output logic            stack_err
);
  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_WAIT   = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [PC_W-1:0]   pc_r, pc_s, pc_inc_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              taken_r, taken_s;
  logic              pc_valid_r, busy_r, timeout_r, timeout_s;

  function automatic logic [PC_W-1:0] sext_offset(input logic [7:0] off);
    return PC_W'($signed(off));
  endfunction

  assign pc_inc_s = pc_r + PC_W'(1);

`ifdef CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_W-1:0]  stack_r [STACK_DEPTH];
  logic [SP_W-1:0]  sp_r;
  logic             err_r;
  logic             push_s, pop_s, err_set_s;
  logic [IDX_W-1:0] push_idx_s, top_idx_s;

  assign push_idx_s = IDX_W'(sp_r);
  assign top_idx_s  = IDX_W'(sp_r - SP_W'(1));
`else
  logic unused_call_s;
  assign unused_call_s = is_call ^ is_ret;
`endif

  // Next-state, next-pc and wait-counter decisions
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    cnt_s     = cnt_r;
    taken_s   = taken_r;
    timeout_s = 1'b0;
`ifdef CALL_STACK_EN
    push_s    = 1'b0;
    pop_s     = 1'b0;
    err_set_s = 1'b0;
`endif
    case (state_r)
      S_FETCH: begin
        // pc_valid_r gates the idle cycle right after reset release
        if (pc_valid_r && instr_valid && !stall) begin
          if (is_jump) begin
            pc_s = jump_target;
          end
`ifdef CALL_STACK_EN
          else if (is_call) begin
            if (sp_r == SP_W'(STACK_DEPTH)) begin
              pc_s      = pc_inc_s;
              err_set_s = 1'b1;
            end else begin
              pc_s   = jump_target;
              push_s = 1'b1;
            end
          end else if (is_ret) begin
            if (sp_r == '0) begin
              pc_s      = pc_inc_s;
              err_set_s = 1'b1;
            end else begin
              pc_s  = stack_r[top_idx_s];
              pop_s = 1'b1;
            end
          end
`endif
          else if (is_branch) begin
            state_s = S_WAIT;
            cnt_s   = '0;
          end else begin
            pc_s = pc_inc_s;
          end
        end else begin
          state_s = S_FETCH;
        end
      end
      S_WAIT: begin
        cnt_s = cnt_r + CNT_W'(1);
        if (alu_done) begin
          taken_s = alu_zero;
          state_s = S_UPDATE;
        end else if (cnt_r == CNT_W'(WAIT_MAX - 1)) begin
          taken_s   = 1'b0;
          timeout_s = 1'b1;
          state_s   = S_UPDATE;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_UPDATE: begin
        if (!stall) begin
          pc_s    = taken_r ? (pc_inc_s + sext_offset(br_offset)) : pc_inc_s;
          state_s = S_FETCH;
        end else begin
          state_s = S_UPDATE;
        end
      end
      default: begin
        state_s = S_FETCH;
      end
    endcase
  end

  // State, pc and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_FETCH;
      pc_r       <= PC_W'(RESET_PC);
      cnt_r      <= '0;
      taken_r    <= 1'b0;
      pc_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      cnt_r      <= cnt_s;
      taken_r    <= taken_s;
      pc_valid_r <= (state_s == S_FETCH);
      busy_r     <= (state_s != S_FETCH);
      timeout_r  <= timeout_s;
    end
  end

`ifdef CALL_STACK_EN
  // Return-address LIFO and sticky overflow/underflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_r  <= '0;
      err_r <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        stack_r[push_idx_s] <= pc_inc_s;
        sp_r                <= sp_r + SP_W'(1);
      end else if (pop_s) begin
        sp_r <= sp_r - SP_W'(1);
      end else begin
        sp_r <= sp_r;
      end
      if (err_set_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign stack_err = err_r;
`else
  assign stack_err = 1'b0;
`endif

  assign pc         = pc_r;
  assign pc_valid   = pc_valid_r;
  assign busy       = busy_r;
  assign br_timeout = timeout_r;

  branch_pc_unit_checker #(.PC_W(PC_W)) u_checker (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .busy       (busy),
    .br_timeout (br_timeout),
    .stack_err  (stack_err)
  );
endmodule
